// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   NOP_INST      : bubble encoding (addi x0,x0,0), shared with the IF/ID register
//   fetch_state_t : fetch-unit FSM state encoding
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one word read at a time to
// instruction memory and buffers the returned instruction until IF/ID takes it.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   stall             : IF/ID cannot accept; hold the presented instruction
//   br_taken          : redirect from EX (wins over stall and consumption)
//   br_target         : redirect PC, low two bits forced to zero
//   imem_req_*        : valid/ready read request, word-aligned address
//   imem_rsp_*        : read response, one cycle or more after acceptance
//   PC_out/Inst       : presented PC and instruction (NOP_INST when none)
//   inst_valid        : Inst is a real fetched instruction
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_REQ  | request for pc is being offered to memory
// S_WAIT | request accepted, waiting for response (drop = squash it)
// S_HOLD | instruction in inst_buf presented until consumed or squashed
module fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PC_out,
    output logic [31:0] Inst,
    output logic        inst_valid
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  inst_buf, inst_buf_n;
    logic         drop, drop_n;
    logic [31:0]  br_pc;

    assign br_pc = br_target & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst_buf <= NOP_INST;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inst_buf <= inst_buf_n;
            drop     <= drop_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_buf_n = inst_buf;
        drop_n     = drop;
        case (state)
            S_REQ: begin
                if (br_taken) begin
                    pc_n = br_pc;
                    // An accepted request for the old pc must still be drained.
                    if (imem_req_ready) begin
                        state_n = S_WAIT;
                        drop_n  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (br_taken) begin
                    pc_n = br_pc;
                    if (imem_rsp_valid) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        inst_buf_n = imem_rsp_data;
                        state_n    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (br_taken) begin
                    pc_n       = br_pc;
                    inst_buf_n = NOP_INST;
                    state_n    = S_REQ;
                end else if (!stall) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
                drop_n  = 1'b0;
            end
        endcase
    end

    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign PC_out         = pc;
    assign inst_valid     = (state == S_HOLD);
    assign Inst           = (state == S_HOLD) ? inst_buf : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan scenarios with literal expectations,
// then randomized stall/branch/backpressure/latency/reset traffic. A
// transaction-level model (expected pc, held instruction, one tagged
// outstanding read) predicts every output on every cycle.
module tb_fetch_unit;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] PC_out;
    logic [31:0] Inst;
    logic        inst_valid;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PC_out         (PC_out),
        .Inst           (Inst),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pres = 0;

    // Model: the pc the unit owns, the instruction it holds (if any) and the
    // single outstanding memory read, tagged stale when a redirect hit it.
    logic [31:0] m_pc   = 32'h0;
    bit          m_held = 1'b0;
    logic [31:0] m_data = NOP_INST;
    bit          m_out  = 1'b0;
    bit          m_stale = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_raddr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // State-derived outputs, sampled at the falling edge.
    task automatic cyc_begin();
        @(negedge clk);
        chk("PC_out", PC_out, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_held});
        chk("Inst", Inst, m_held ? m_data : NOP_INST);
    endtask

    // Drive this cycle's inputs, check the request side, advance the model.
    task automatic cyc_end(input bit s, input bit b, input logic [31:0] t,
                           input bit r, input int lat, input bit rst);
        bit exp_rv, rsp, acc, consume;
        reset = rst; stall = s; br_taken = b; br_target = t; imem_req_ready = r;
        exp_rv = !m_held && !m_out;
        rsp = 1'b0;
        if (m_out) begin
            m_cnt--;
            rsp = (m_cnt == 0);
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(m_raddr) : $urandom;
        #1;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv && !rst});
        if (exp_rv && !rst) chk("req_addr", imem_req_addr, m_pc);
        if (rst) begin
            m_pc = 32'h0; m_held = 1'b0; m_data = NOP_INST;
            m_out = 1'b0; m_stale = 1'b0; m_cnt = 0;
            return;
        end
        consume = m_held && !s && !b;
        if (rsp) begin
            m_out = 1'b0;
            if (!m_stale && !b) begin
                m_held = 1'b1;
                m_data = mem_word(m_raddr);
            end
            m_stale = 1'b0;
        end
        acc = exp_rv && r;
        if (acc) begin
            m_out = 1'b1; m_cnt = lat; m_raddr = m_pc; m_stale = 1'b0;
        end
        if (b) begin
            m_pc = {t[31:2], 2'b00};
            m_held = 1'b0;
            if (m_out) m_stale = 1'b1;
        end else if (consume) begin
            m_held = 1'b0;
            m_pc = m_pc + 32'd4;
            n_pres++;
        end
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit r, input int lat);
        cyc_begin();
        cyc_end(s, b, t, r, lat, 1'b0);
    endtask

    initial begin
        // Reset for two cycles.
        for (int i = 0; i < 2; i++) begin
            cyc_begin();
            cyc_end(0, 0, 0, 0, 1, 1);
        end

        // Reset, 1-cycle memory.
        cyc_begin();
        chk("rst PC_out", PC_out, 32'h0);
        chk("rst Inst", Inst, 32'h0000_0013);
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("t1 req_addr", imem_req_addr, 32'h0);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("t1 Inst", Inst, 32'h0050_0093);
        chk("t1 PC_out", PC_out, 32'h0);
        chk("t1 valid", {31'b0, inst_valid}, 32'h1);
        cyc_end(0, 0, 0, 1, 1, 0);
        cyc_begin();
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("t1 next addr", imem_req_addr, 32'h4);

        // Stall hold for 4 cycles.
        step(0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            cyc_begin();
            chk("stall PC_out", PC_out, 32'h4);
            chk("stall Inst", Inst, 32'hC0DE_0004);
            cyc_end(1, 0, 0, 1, 1, 0);
            chk("stall no req", {31'b0, imem_req_valid}, 32'h0);
        end
        step(0, 0, 0, 1, 1);
        cyc_begin();
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("stall next addr", imem_req_addr, 32'h8);

        // Branch in S_HOLD.
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("hold PC_out", PC_out, 32'h8);
        cyc_end(1, 1, 32'h100, 1, 1, 0);
        cyc_begin();
        chk("brhold valid", {31'b0, inst_valid}, 32'h0);
        cyc_end(0, 0, 0, 1, 3, 0);
        chk("brhold addr", imem_req_addr, 32'h100);

        // Branch in S_WAIT with 3-cycle memory.
        step(0, 1, 32'h203, 1, 1);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("brwait rsp cycle noreq", {31'b0, imem_req_valid}, 32'h0);
        cyc_begin();
        chk("brwait dropped", {31'b0, inst_valid}, 32'h0);
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("brwait addr", imem_req_addr, 32'h200);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("brwait Inst", Inst, 32'hC0DE_0200);
        chk("brwait PC_out", PC_out, 32'h200);
        cyc_end(0, 0, 0, 1, 1, 0);

        // Branch in the same cycle a request is accepted.
        cyc_begin();
        cyc_end(0, 1, 32'h300, 1, 2, 0);
        cyc_begin();
        chk("bracc PC_out", PC_out, 32'h300);
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("bracc waiting", {31'b0, imem_req_valid}, 32'h0);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("bracc dropped", {31'b0, inst_valid}, 32'h0);
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("bracc addr", imem_req_addr, 32'h300);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("bracc Inst", Inst, 32'hC0DE_0300);
        cyc_end(0, 1, 32'hFFFF_FFFF, 1, 1, 0);

        // Backpressure for 5 cycles, then wrap.
        for (int k = 0; k < 5; k++) begin
            cyc_begin();
            cyc_end(0, 0, 0, 0, 1, 0);
            chk("bp addr", imem_req_addr, 32'hFFFF_FFFC);
            chk("bp valid", {31'b0, imem_req_valid}, 32'h1);
        end
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        cyc_begin();
        chk("wrap PC_out", PC_out, 32'hFFFF_FFFC);
        chk("wrap Inst", Inst, 32'h3F21_FFFC);
        cyc_end(0, 0, 0, 1, 1, 0);
        cyc_begin();
        chk("wrap pc", PC_out, 32'h0);
        cyc_end(0, 0, 0, 1, 1, 0);
        chk("wrap addr", imem_req_addr, 32'h0);

        // Randomized traffic, including mid-operation resets.
        n_pres = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc_begin();
            cyc_end(($urandom % 10) < 3, ($urandom % 20) == 0, $urandom,
                    ($urandom % 10) < 7, 1 + int'($urandom % 4),
                    ($urandom % 500) == 0);
        end
        chk("random progress", {31'b0, n_pres > 100}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
